// File: rtl/imem_pkg.sv
// Shared constants for the instruction memory pipeline: NOP word, fault bit
// positions, legal latency range and the parity helper.
package imem_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam int FLT_MISALIGN = 0;
  localparam int FLT_RANGE    = 1;
  localparam int FLT_PARITY   = 2;
  localparam int FAULT_W      = 3;

  localparam int LATENCY_MIN  = 1;
  localparam int LATENCY_MAX  = 4;

  function automatic logic even_parity(input logic [31:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/imem_storage.sv
// Word storage with per-word written flags and registered read port.
// Optional per-word even parity when IMEM_PARITY_EN is defined.
module imem_storage
  import imem_pkg::*;
#(
  parameter int DEPTH = 128,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rd_en_i,
  input  logic [AW-1:0] rd_idx_i,
  input  logic          rd_kill_i,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_idx_i,
  input  logic [31:0]   wr_data_i,
  output logic [31:0]   rd_instr_o,
  output logic          rd_perr_o
);

  logic [31:0]      mem_q [DEPTH];
  logic [DEPTH-1:0] written_q;
  logic             perr_s;
  logic [31:0]      rd_instr_d;
  logic             rd_perr_d;
  logic [31:0]      rd_instr_q;
  logic             rd_perr_q;

  // Array contents are not reset; the written flags qualify them.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_idx_i] <= wr_data_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      written_q <= '0;
    end else if (wr_en_i) begin
      written_q[wr_idx_i] <= 1'b1;
    end
  end

`ifdef IMEM_PARITY_EN
  logic [DEPTH-1:0] par_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      par_q[wr_idx_i] <= even_parity(wr_data_i);
    end
  end

  assign perr_s = written_q[rd_idx_i] &&
                  (even_parity(mem_q[rd_idx_i]) != par_q[rd_idx_i]);
`else
  assign perr_s = 1'b0;
`endif

  // Read samples the array before a same-edge write lands, giving old data.
  always_comb begin
    rd_perr_d  = perr_s && !rd_kill_i;
    rd_instr_d = written_q[rd_idx_i] ? mem_q[rd_idx_i] : NOP_INSTR;
    if (rd_kill_i || rd_perr_d) begin
      rd_instr_d = 32'h0000_0000;
    end else begin
      rd_instr_d = rd_instr_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_instr_q <= 32'h0000_0000;
      rd_perr_q  <= 1'b0;
    end else if (rd_en_i) begin
      rd_instr_q <= rd_instr_d;
      rd_perr_q  <= rd_perr_d;
    end
  end

  assign rd_instr_o = rd_instr_q;
  assign rd_perr_o  = rd_perr_q;

endmodule

// File: rtl/instr_mem_pipe.sv
// LATENCY-stage instruction fetch pipeline with valid/ready handshake and a
// program write port. Parity checking is enabled by defining IMEM_PARITY_EN.
module instr_mem_pipe
  import imem_pkg::*;
#(
  parameter int DEPTH   = 128,
  parameter int LATENCY = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [31:0]         req_addr,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [31:0]         rsp_instr,
  output logic [FAULT_W-1:0]  rsp_fault,
  input  logic                prog_we,
  input  logic [31:0]         prog_addr,
  input  logic [31:0]         prog_data
);

  localparam int          AW    = $clog2(DEPTH);
  localparam logic [31:0] BYTES = 32'(4 * DEPTH);

  logic                 adv_s;
  logic                 wr_ok_s;
  logic [FLT_RANGE:0]   addr_flt_s;
  logic                 s0_val_q;
  logic [FLT_RANGE:0]   s0_flt_q;
  logic [31:0]          st_instr_s;
  logic                 st_perr_s;
  logic                 st_val_s [LATENCY];
  logic [FAULT_W-1:0]   st_flt_s [LATENCY];
  logic [31:0]          st_ins_s [LATENCY];

  assign req_ready = !rsp_valid || rsp_ready;
  assign adv_s     = req_ready;
  assign wr_ok_s   = prog_we && (prog_addr[1:0] == 2'b00) && (prog_addr < BYTES);

  always_comb begin
    addr_flt_s               = '0;
    addr_flt_s[FLT_MISALIGN] = |req_addr[1:0];
    addr_flt_s[FLT_RANGE]    = (req_addr >= BYTES);
  end

  // Stage 0 control; its data half lives in the storage read register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_val_q <= 1'b0;
      s0_flt_q <= '0;
    end else if (adv_s) begin
      s0_val_q <= req_valid;
      s0_flt_q <= addr_flt_s;
    end
  end

  imem_storage #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_storage (
    .clk        (clk),
    .rst        (rst),
    .rd_en_i    (adv_s),
    .rd_idx_i   (req_addr[AW+1:2]),
    .rd_kill_i  (|addr_flt_s),
    .wr_en_i    (wr_ok_s),
    .wr_idx_i   (prog_addr[AW+1:2]),
    .wr_data_i  (prog_data),
    .rd_instr_o (st_instr_s),
    .rd_perr_o  (st_perr_s)
  );

  assign st_val_s[0] = s0_val_q;
  assign st_flt_s[0] = {st_perr_s, s0_flt_q};
  assign st_ins_s[0] = st_instr_s;

  for (genvar k = 1; k < LATENCY; k++) begin : g_stage
    logic               v_q;
    logic [FAULT_W-1:0] f_q;
    logic [31:0]        i_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v_q <= 1'b0;
        f_q <= '0;
        i_q <= 32'h0000_0000;
      end else if (adv_s) begin
        v_q <= st_val_s[k-1];
        f_q <= st_flt_s[k-1];
        i_q <= st_ins_s[k-1];
      end
    end

    assign st_val_s[k] = v_q;
    assign st_flt_s[k] = f_q;
    assign st_ins_s[k] = i_q;
  end

  assign rsp_valid = st_val_s[LATENCY-1];
  assign rsp_fault = st_flt_s[LATENCY-1];
  assign rsp_instr = st_ins_s[LATENCY-1];

endmodule

// File: tb/tb_instr_mem_pipe.sv
// Directed bench: a LATENCY=1 and a LATENCY=3 instance share request and
// program inputs; the LATENCY=3 instance always accepts responses.
module tb_instr_mem_pipe;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        rsp_ready;
  logic        prog_we;
  logic [31:0] prog_addr;
  logic [31:0] prog_data;

  logic        req_ready,  rsp_valid;
  logic [31:0] rsp_instr;
  logic [2:0]  rsp_fault;
  logic        req_ready3, rsp_valid3;
  logic [31:0] rsp_instr3;
  logic [2:0]  rsp_fault3;

  int checks   = 0;
  int failures = 0;

  instr_mem_pipe #(.DEPTH(128), .LATENCY(1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_instr(rsp_instr), .rsp_fault(rsp_fault), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_data(prog_data)
  );

  instr_mem_pipe #(.DEPTH(128), .LATENCY(3)) dut3 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready3),
    .req_addr(req_addr), .rsp_valid(rsp_valid3), .rsp_ready(1'b1),
    .rsp_instr(rsp_instr3), .rsp_fault(rsp_fault3), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_data(prog_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic prog(input logic [31:0] a, input logic [31:0] d);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    step();
    prog_we = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] a);
    req_valid = 1'b1; req_addr = a;
    step();
    req_valid = 1'b0;
  endtask

  logic [31:0] exp_w [4];
  int          sent;
  int          recv;
  logic        acc;

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_addr = 32'h0; rsp_ready = 1'b1;
    prog_we = 1'b0; prog_addr = 32'h0; prog_data = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", {31'h0, rsp_valid}, 32'h0);
    check("rst_instr", rsp_instr, 32'h0);
    check("rst_fault", {29'h0, rsp_fault}, 32'h0);
    rst = 1'b0;
    #1;
    check("rst_ready", {31'h0, req_ready}, 32'h1);

    // Unwritten word returns NOP one cycle later.
    fetch(32'h0);
    check("nop_valid", {31'h0, rsp_valid}, 32'h1);
    check("nop_instr", rsp_instr, 32'h0000_0013);
    check("nop_fault", {29'h0, rsp_fault}, 32'h0);
    step();
    check("bubble", {31'h0, rsp_valid}, 32'h0);

    // Programmed word, latency 1 and 3; misaligned fetch.
    prog(32'h10, 32'h00A0_0093);
    repeat (3) step();
    fetch(32'h10);
    check("l1_instr", rsp_instr, 32'h00A0_0093);
    check("l3_c1", {31'h0, rsp_valid3}, 32'h0);
    step();
    check("l3_c2", {31'h0, rsp_valid3}, 32'h0);
    step();
    check("l3_c3", {31'h0, rsp_valid3}, 32'h1);
    check("l3_instr", rsp_instr3, 32'h00A0_0093);
    fetch(32'h12);
    check("mis_fault", {29'h0, rsp_fault}, 32'h1);
    check("mis_instr", rsp_instr, 32'h0);

    // Out of range fetch and ignored writes.
    fetch(32'h200);
    check("oor_fault", {29'h0, rsp_fault}, 32'h2);
    check("oor_instr", rsp_instr, 32'h0);
    prog(32'h200, 32'hDEAD_BEEF);
    prog(32'h2, 32'hCAFE_F00D);
    fetch(32'h0);
    check("oor_wr_ignored", rsp_instr, 32'h0000_0013);
    check("oor_wr_fault", {29'h0, rsp_fault}, 32'h0);

    // Back-to-back fetches with a 3-cycle consumer stall.
    for (int i = 0; i < 4; i++) begin
      exp_w[i] = 32'hA000_0001 + 32'(i * 32'h0101_0000);
      prog(32'h40 + 32'(4 * i), exp_w[i]);
    end
    sent = 0; recv = 0;
    for (int c = 0; c < 20 && recv < 4; c++) begin
      rsp_ready = !(c >= 1 && c <= 3);
      req_valid = (sent < 4);
      req_addr  = 32'h40 + 32'(4 * sent);
      #2;
      if (c >= 1 && c <= 3) begin
        check("stall_ready", {31'h0, req_ready}, 32'h0);
        check("stall_valid", {31'h0, rsp_valid}, 32'h1);
        check("stall_hold", rsp_instr, exp_w[recv]);
      end
      if (rsp_valid && rsp_ready) begin
        check("order", rsp_instr, exp_w[recv]);
        recv++;
      end
      acc = req_valid && req_ready;
      @(posedge clk);
      if (acc) sent++;
      #1;
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    #2;
    check("recv_count", 32'(recv), 32'd4);
    check("sent_count", 32'(sent), 32'd4);
    check("no_dup", {31'h0, rsp_valid}, 32'h0);
    step();

    // Same-cycle write and fetch return old data.
    prog(32'h20, 32'h2222_2222);
    prog_we = 1'b1; prog_addr = 32'h20; prog_data = 32'h1111_1111;
    req_valid = 1'b1; req_addr = 32'h20;
    step();
    prog_we = 1'b0; req_valid = 1'b0;
    check("rw_old", rsp_instr, 32'h2222_2222);
    fetch(32'h20);
    check("rw_new", rsp_instr, 32'h1111_1111);

    // Reset with two fetches in flight on the latency-3 instance.
    repeat (3) step();
    fetch(32'h10);
    fetch(32'h20);
    check("inflight_pre", {31'h0, rsp_valid3}, 32'h0);
    rst = 1'b1;
    #1;
    check("inflight_rst", {31'h0, rsp_valid3}, 32'h0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("no_stale", {31'h0, rsp_valid3}, 32'h0);
    end
    fetch(32'h10);
    check("flags_cleared", rsp_instr, 32'h0000_0013);

`ifdef IMEM_PARITY_EN
    prog(32'h30, 32'h1234_5678);
    dut.u_storage.par_q[12] = ~dut.u_storage.par_q[12];
    fetch(32'h30);
    check("par_fault", {29'h0, rsp_fault}, 32'h4);
    check("par_instr", rsp_instr, 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
